stream_demux_1_n: RTL and testbench

Parametrised, registered 1:N demultiplexer for valid/ready streams. It is the successor to the combinational 1:8 demux and adds configurable channel count and data width. It also adds a per-channel output register, backpressure, and an optional packet mode that holds the routing select from the first beat to the last beat of a packet. It sits between a single producer and N independent consumers.

---
 rtl/demux_pkg.sv | 22 ++
 rtl/stream_reg_slot.sv | 36 +++
 rtl/stream_demux_1_n.sv | 105 ++++++++++
 tb/tb_stream_demux_1_n.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared definitions for the registered 1:N stream demultiplexer:
// default widths, routing-FSM states and a ceil-log2 helper.
package demux_pkg;

   localparam int unsigned DEF_N_CH   = 8;
   localparam int unsigned DEF_DATA_W = 1;
   localparam int unsigned DEF_SEL_W  = 3;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOCKED = 2'd1,
      ST_DROP   = 2'd2
   } state_t;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned result;
      result = 0;
      while ((32'd1 << result) < value) result++;
      return result;
   endfunction

endpackage

// File: rtl/stream_reg_slot.sv
// Single-entry valid/ready output register holding one beat (data + last).
// The entry can be refilled in the same cycle it drains.
module stream_reg_slot
   import demux_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_last,
   input  logic              out_ready,
   output logic              can_take,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last
);

   assign can_take = !out_valid || out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
      end else if (load) begin
         out_valid <= 1'b1;
         out_data  <= in_data;
         out_last  <= in_last;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/stream_demux_1_n.sv
// Registered 1:N valid/ready demultiplexer with per-channel output slots,
// backpressure and an optional packet mode that locks the route per packet.
module stream_demux_1_n
   import demux_pkg::*;
#(
   parameter int unsigned N_CH     = DEF_N_CH,
   parameter int unsigned DATA_W   = DEF_DATA_W,
   parameter int unsigned SEL_W    = DEF_SEL_W,
   parameter int unsigned PKT_MODE = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     s_valid,
   output logic                     s_ready,
   input  logic [DATA_W-1:0]        s_data,
   input  logic [SEL_W-1:0]         s_sel,
   input  logic                     s_last,
   output logic [N_CH-1:0]          m_valid,
   input  logic [N_CH-1:0]          m_ready,
   output logic [N_CH*DATA_W-1:0]   m_data,
   output logic [N_CH-1:0]          m_last,
   output logic                     err_sel
);

   if (N_CH < 2 || N_CH > 256) begin : g_bad_n_ch
      $error("stream_demux_1_n: N_CH must be within 2..256");
   end
   if (N_CH > (1 << SEL_W)) begin : g_bad_sel_w
      $error("stream_demux_1_n: N_CH exceeds 2**SEL_W");
   end

   localparam logic [SEL_W:0] N_CH_L = (SEL_W+1)'(N_CH);

   state_t            state;
   logic [SEL_W-1:0]  sel_q;
   logic [SEL_W-1:0]  eff_sel;
   logic              sel_ok;
   logic              dropping;
   logic              first_beat;
   logic              accept;
   logic [N_CH-1:0]   hit;
   logic [N_CH-1:0]   can_take;
   logic [N_CH-1:0]   load;

   always_comb begin
      eff_sel    = (PKT_MODE != 0 && state == ST_LOCKED) ? sel_q : s_sel;
      sel_ok     = {1'b0, eff_sel} < N_CH_L;
      // in DROP the live s_sel is irrelevant: the whole packet is discarded
      dropping   = !sel_ok || state == ST_DROP;
      first_beat = (PKT_MODE == 0) || state == ST_IDLE;
      hit        = '0;
      for (int unsigned k = 0; k < N_CH; k++) begin
         hit[k] = (eff_sel == SEL_W'(k));
      end
      s_ready = dropping ? 1'b1 : |(hit & can_take);
      accept  = s_valid && s_ready;
      load    = hit & {N_CH{accept && !dropping}};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         sel_q   <= '0;
         err_sel <= 1'b0;
      end else begin
         err_sel <= accept && !sel_ok && first_beat;
         if (PKT_MODE != 0 && accept) begin
            case (state)
               ST_IDLE: begin
                  if (!s_last) begin
                     if (sel_ok) begin
                        state <= ST_LOCKED;
                        sel_q <= s_sel;
                     end else begin
                        state <= ST_DROP;
                     end
                  end
               end
               ST_LOCKED, ST_DROP: begin
                  if (s_last) state <= ST_IDLE;
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

   for (genvar k = 0; k < N_CH; k++) begin : g_ch
      stream_reg_slot #(
         .DATA_W(DATA_W)
      ) u_slot (
         .clk       (clk),
         .rst_n     (rst_n),
         .load      (load[k]),
         .in_data   (s_data),
         .in_last   (s_last),
         .out_ready (m_ready[k]),
         .can_take  (can_take[k]),
         .out_valid (m_valid[k]),
         .out_data  (m_data[k*DATA_W +: DATA_W]),
         .out_last  (m_last[k])
      );
   end

endmodule

// File: tb/tb_stream_demux_1_n.sv
// Randomised self-checking bench: a per-beat demux (8 channels) and a packet-mode
// demux (6 channels, so selects 6/7 are invalid) driven side by side.
module tb_stream_demux_1_n;

   localparam int unsigned DW = 4;

   logic          clk;
   logic          rst_n;
   logic          s_valid;
   logic [DW-1:0] s_data;
   logic [2:0]    s_sel;
   logic          s_last;
   logic [7:0]    m_ready_v;

   logic          s_ready_a;
   logic [7:0]    m_valid_a;
   logic [8*DW-1:0] m_data_a;
   logic [7:0]    m_last_a;
   logic          err_sel_a;

   logic          s_ready_b;
   logic [5:0]    m_valid_b;
   logic [6*DW-1:0] m_data_b;
   logic [5:0]    m_last_b;
   logic          err_sel_b;

   int unsigned n_cmp;
   int unsigned n_err;

   stream_demux_1_n #(.N_CH(8), .DATA_W(DW), .SEL_W(3), .PKT_MODE(0)) dut_a (
      .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready_a),
      .s_data(s_data), .s_sel(s_sel), .s_last(s_last),
      .m_valid(m_valid_a), .m_ready(m_ready_v), .m_data(m_data_a),
      .m_last(m_last_a), .err_sel(err_sel_a)
   );

   stream_demux_1_n #(.N_CH(6), .DATA_W(DW), .SEL_W(3), .PKT_MODE(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready_b),
      .s_data(s_data), .s_sel(s_sel), .s_last(s_last),
      .m_valid(m_valid_b), .m_ready(m_ready_v[5:0]), .m_data(m_data_b),
      .m_last(m_last_b), .err_sel(err_sel_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference model state, index 0 = per-beat DUT, 1 = packet DUT
   bit          ev [2][8];
   logic [DW-1:0] ed [2][8];
   bit          el [2][8];
   bit          eerr [2];
   bit          in_pkt [2];
   bit          pkt_dropped [2];
   int unsigned pkt_ch [2];

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         for (int k = 0; k < 8; k++) begin
            ev[d][k] = 1'b0; ed[d][k] = '0; el[d][k] = 1'b0;
         end
         eerr[d] = 1'b0; in_pkt[d] = 1'b0; pkt_dropped[d] = 1'b0; pkt_ch[d] = 0;
      end
   endtask

   task automatic check_outputs(input int d);
      logic [63:0] xv, xd, xl, av, ad, al, ae;
      int unsigned nch;
      nch = (d == 0) ? 8 : 6;
      xv = '0; xd = '0; xl = '0;
      for (int k = 0; k < int'(nch); k++) begin
         xv[k] = ev[d][k];
         xd[k*DW +: DW] = ed[d][k];
         xl[k] = el[d][k];
      end
      if (d == 0) begin
         av = 64'(m_valid_a); ad = 64'(m_data_a); al = 64'(m_last_a); ae = 64'(err_sel_a);
      end else begin
         av = 64'(m_valid_b); ad = 64'(m_data_b); al = 64'(m_last_b); ae = 64'(err_sel_b);
      end
      check_eq(d == 0 ? "a.m_valid" : "b.m_valid", av, xv);
      check_eq(d == 0 ? "a.m_data"  : "b.m_data",  ad, xd);
      check_eq(d == 0 ? "a.m_last"  : "b.m_last",  al, xl);
      check_eq(d == 0 ? "a.err_sel" : "b.err_sel", ae, 64'(eerr[d]));
   endtask

   // Evaluates the current (settled) inputs, checks s_ready, then advances the
   // model to what the outputs must show after the coming rising edge.
   task automatic model_step(input int d, input logic rdy_obs);
      bit pkt, drop, rdy, acc;
      int unsigned nch, ch;
      pkt = (d == 1);
      nch = (d == 0) ? 8 : 6;
      ch  = (pkt && in_pkt[d]) ? pkt_ch[d] : int'(s_sel);
      drop = (pkt && in_pkt[d] && pkt_dropped[d]) || ch >= nch;
      rdy  = drop ? 1'b1 : (!ev[d][ch] || m_ready_v[ch]);
      check_eq(d == 0 ? "a.s_ready" : "b.s_ready", 64'(rdy_obs), 64'(rdy));
      acc = s_valid && rdy;
      for (int k = 0; k < int'(nch); k++) begin
         if (m_ready_v[k]) ev[d][k] = 1'b0;
      end
      if (acc && !drop) begin
         ev[d][ch] = 1'b1; ed[d][ch] = s_data; el[d][ch] = s_last;
      end
      eerr[d] = acc && drop && (!pkt || !in_pkt[d]);
      if (pkt && acc) begin
         if (!in_pkt[d]) begin
            if (!s_last) begin
               in_pkt[d] = 1'b1; pkt_ch[d] = ch; pkt_dropped[d] = (ch >= nch);
            end
         end else if (s_last) begin
            in_pkt[d] = 1'b0;
         end
      end
   endtask

   initial begin
      int unsigned phase;
      n_cmp = 0; n_err = 0;
      rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_sel = '0; s_last = 1'b0; m_ready_v = '0;
      model_reset();
      repeat (3) @(negedge clk);
      check_outputs(0); check_outputs(1);
      rst_n = 1'b1;

      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         if (cyc == 700 || cyc == 1500 || cyc == 2300) begin
            // asynchronous reset mid-stream: outputs clear without a clock edge
            #2 rst_n = 1'b0;
            #1;
            model_reset();
            check_outputs(0); check_outputs(1);
            @(negedge clk);
            rst_n = 1'b1;
         end
         check_outputs(0); check_outputs(1);

         phase = (cyc / 200) % 3;
         s_valid = ($urandom_range(3) != 0);
         s_data  = DW'($urandom);
         s_sel   = 3'($urandom);
         s_last  = ($urandom_range(3) == 0);
         for (int k = 0; k < 8; k++) begin
            case (phase)
               0: m_ready_v[k] = ($urandom_range(3) != 0);
               1: m_ready_v[k] = ($urandom_range(3) == 0);
               default: m_ready_v[k] = 1'b1;
            endcase
         end
         #1;
         model_step(0, s_ready_a);
         model_step(1, s_ready_b);
      end
      @(negedge clk);
      check_outputs(0); check_outputs(1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
